// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the mrhankey fetch stage: HALT opcode, fetch-state
// encoding and opcode field constants used by the fetch and decode sides.
package fetch_unit_pkg;

  localparam logic [7:0] HALT_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  // Top two opcode bits select the instruction class.
  localparam logic [1:0] OPC_LDA = 2'b00;
  localparam logic [1:0] OPC_LDB = 2'b01;
  localparam logic [1:0] OPC_ADD = 2'b10;

  function automatic logic [1:0] opc_class(input logic [7:0] op);
    return op[7:6];
  endfunction

endpackage

// File: rtl/ip_counter.sv
// Instruction-pointer register: up-counter with synchronous load (jump) and
// count enable (sequential advance). Wraps modulo 2^W.
module ip_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld)      q_d = ld_val;
    else if (en) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: requests bytes at IP over req/ack, holds them in IR for the
// decoder over valid/ready, advances/redirects IP on retire, stops on HALT.
module fetch_unit #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] HALT_OP = fetch_unit_pkg::HALT_OP,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              halted,
  output logic [ADDR_W-1:0] ip,
  output logic [CNT_W-1:0]  retired
);

  import fetch_unit_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [ADDR_W-1:0] ip_q;
  logic              retire, ip_ld, ip_en;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    ip_ld     = 1'b0;
    ip_en     = 1'b0;
    retire    = (state_q == ISSUE) && ir_ready;
    case (state_q)
      IDLE: if (run) state_d = REQ;
      // An outstanding request always completes, even if run has dropped.
      REQ: if (mem_ack) begin
        ir_d    = mem_rdata;
        state_d = ISSUE;
      end
      ISSUE: if (retire) begin
        retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
        if (ir_q == HALT_OP) begin
          state_d = HALTED;
        end else begin
          ip_ld   = jmp_valid;
          ip_en   = !jmp_valid;
          state_d = run ? REQ : IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  ip_counter #(.W(ADDR_W)) u_ip (
    .clk    (clk),
    .clr_n  (clr_n),
    .ld     (ip_ld),
    .en     (ip_en),
    .ld_val (jmp_addr),
    .q      (ip_q)
  );

  assign mem_req  = (state_q == REQ);
  assign ir_valid = (state_q == ISSUE);
  assign halted   = (state_q == HALTED);
  assign mem_addr = ip_q;
  assign ip       = ip_q;
  assign ir       = ir_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program memory responder, transaction-level model of
// the instruction stream checked every cycle, plus directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clr_n, run, mem_ack, ir_ready, jmp_valid;
  logic [7:0]  mem_rdata, jmp_addr;
  logic        mem_req, ir_valid, halted;
  logic [7:0]  mem_addr, ir, ip;
  logic [15:0] retired;

  fetch_unit dut (
    .clk(clk), .clr_n(clr_n), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .halted(halted), .ip(ip), .retired(retired)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Program memory and jump table (jump taken whenever IP points at an entry).
  logic [7:0] mem [256];
  logic       jt_v [256];
  logic [7:0] jt_a [256];
  int         wait_n = 0;
  bit         spur   = 0;
  int         wcnt   = 0;

  assign jmp_valid = jt_v[ip];
  assign jmp_addr  = jt_a[ip];

  always @(posedge clk) begin
    #2;
    if (!clr_n || !mem_req) begin
      wcnt      = 0;
      mem_ack   = spur;
      mem_rdata = spur ? 8'hAA : 8'h00;
    end else if (wcnt >= wait_n) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      wcnt      = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  // Model: where fetch should be, what IR should hold, how many retired.
  logic [7:0]  m_ip, m_ir;
  logic [15:0] m_cnt;
  bit          m_pend, m_halt;
  int          req_len;
  logic [7:0]  log_q [$];

  always @(negedge clk) begin
    if (!clr_n) begin
      m_ip = 0; m_ir = 0; m_cnt = 0; m_pend = 0; m_halt = 0; req_len = 0;
    end else begin
      chk("ip", ip, m_ip);
      chk("mem_addr", mem_addr, m_ip);
      chk("retired", retired, m_cnt);
      chk("halted", halted, m_halt);
      chk("ir_valid", ir_valid, m_pend);
      if (m_pend) chk("ir", ir, m_ir);
      if (mem_req) chk("req_while_busy", m_pend | m_halt, 0);
      if (m_halt) chk("req_after_halt", mem_req, 0);
      if (mem_req) req_len++;
      if (mem_req && mem_ack) begin
        chk("req_len", req_len, wait_n + 1);
        m_pend = 1; m_ir = mem[m_ip]; req_len = 0;
      end else if (m_pend && ir_ready) begin
        log_q.push_back(m_ir);
        if (m_cnt != 16'hFFFF) m_cnt++;
        m_pend = 0;
        if (m_ir == 8'hFF) m_halt = 1;
        else m_ip = jmp_valid ? jmp_addr : m_ip + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    clr_n = 0; run = 0; ir_ready = 1; spur = 0; wait_n = 0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; jt_v[i] = 0; jt_a[i] = 8'h00; end
    log_q.delete();
    repeat (2) @(posedge clk);
    #1 clr_n = 1;
  endtask

  task automatic load_basic();
    mem[0] = 8'h05; mem[1] = 8'h6B; mem[2] = 8'h84; mem[3] = 8'hFF;
  endtask

  task automatic wait_halt(input string name);
    for (int n = 0; n < 300 && !halted; n++) tick();
    chk(name, halted, 1);
  endtask

  task automatic check_seq(input string name);
    logic [7:0] exp [4];
    exp = '{8'h05, 8'h6B, 8'h84, 8'hFF};
    chk({name, "_len"}, log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk({name, "_ir"}, log_q[i], exp[i]);
  endtask

  initial begin
    bit found;
    clr_n = 0; run = 0; ir_ready = 1; mem_ack = 0; mem_rdata = 0;
    #400000 $display("FAIL global_timeout"); $fatal(1);
  end

  initial begin
    bit found;
    // 1: straight line, zero wait
    reset_dut(); load_basic();
    chk("rst_ip", ip, 0); chk("rst_ir", ir, 0); chk("rst_req", mem_req, 0);
    chk("rst_iv", ir_valid, 0); chk("rst_halt", halted, 0); chk("rst_ret", retired, 0);
    run = 1; tick();
    chk("lat_req", mem_req, 1); chk("lat_iv0", ir_valid, 0);
    tick();
    chk("lat_iv", ir_valid, 1); chk("lat_ir", ir, 8'h05);
    wait_halt("s1_halt");
    chk("s1_ip", ip, 3); chk("s1_ret", retired, 4);
    repeat (4) tick();
    chk("s1_req_after", mem_req, 0); chk("s1_ir_hold", ir, 8'hFF);
    check_seq("s1");

    // 2: three wait states per request
    reset_dut(); load_basic(); wait_n = 3; run = 1;
    wait_halt("s2_halt");
    chk("s2_ip", ip, 3); chk("s2_ret", retired, 4);
    check_seq("s2");

    // 3: backpressure on 6B
    reset_dut(); load_basic(); run = 1; found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      tick();
      if (ir_valid && ir == 8'h6B) begin found = 1; ir_ready = 0; end
    end
    chk("bp_found", found, 1);
    repeat (5) begin
      tick();
      chk("bp_iv", ir_valid, 1); chk("bp_ir", ir, 8'h6B);
      chk("bp_req", mem_req, 0); chk("bp_ip", ip, 1);
    end
    ir_ready = 1; tick();
    chk("bp_adv", ip, 2);
    wait_halt("s3_halt");
    check_seq("s3");

    // 4: jump at ip=1 to 10, jump at 10 to FF, FF wraps to 00
    reset_dut();
    mem[0] = 8'h05; mem[1] = 8'h6B; mem[2] = 8'hFF; mem[8'h10] = 8'h84; mem[8'hFF] = 8'h11;
    jt_v[1] = 1; jt_a[1] = 8'h10; jt_v[8'h10] = 1; jt_a[8'h10] = 8'hFF;
    run = 1; found = 0;
    for (int n = 0; n < 50 && !found; n++) begin tick(); found = mem_req && mem_addr == 8'h10; end
    chk("jmp_hit", found, 1); chk("jmp_ret", retired, 2);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin tick(); found = mem_req && mem_addr == 8'hFF; end
    chk("jmp_ff", found, 1); chk("jmp_ff_ret", retired, 3);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin tick(); found = mem_req && mem_addr == 8'h00; end
    chk("wrap_hit", found, 1); chk("wrap_ret", retired, 4); chk("wrap_ip", ip, 0);
    chk("wrap_halt", halted, 0);

    // 5: run dropped mid-request
    reset_dut(); load_basic(); wait_n = 2; run = 1;
    tick();
    chk("rg_req", mem_req, 1);
    run = 0; found = 0;
    for (int n = 0; n < 20 && !found; n++) begin tick(); found = ir_valid; end
    chk("rg_issue", found, 1); chk("rg_ir", ir, 8'h05);
    tick();
    chk("rg_idle_req", mem_req, 0); chk("rg_idle_iv", ir_valid, 0);
    chk("rg_ip", ip, 1); chk("rg_ret", retired, 1);
    spur = 1;
    repeat (3) tick();
    chk("rg_spur_req", mem_req, 0); chk("rg_spur_ir", ir, 8'h05); chk("rg_spur_ip", ip, 1);
    spur = 0; run = 1; tick();
    chk("rg_resume", mem_req, 1); chk("rg_resume_addr", mem_addr, 1);
    wait_halt("s5_halt");
    check_seq("s5");

    // 6: async reset mid-request
    reset_dut(); load_basic(); wait_n = 5; run = 1; found = 0;
    for (int n = 0; n < 100 && !found; n++) begin tick(); found = mem_req && retired == 2; end
    chk("ar_found", found, 1);
    tick();
    #2 clr_n = 0;
    #1;
    chk("ar_req", mem_req, 0); chk("ar_iv", ir_valid, 0); chk("ar_halt", halted, 0);
    chk("ar_ip", ip, 0); chk("ar_ret", retired, 0); chk("ar_ir", ir, 0);
    log_q.delete();
    tick(); clr_n = 1;
    tick();
    chk("ar_restart", mem_req, 1); chk("ar_restart_addr", mem_addr, 0);
    wait_halt("s6_halt");
    check_seq("s6");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
